// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and elaboration helpers for the parametrised synchronous FIFO.
//   fifo_mode_e : STD (registered read) or FWFT (first-word-fall-through)
//   cnt_w       : width of an occupancy counter able to hold 0..depth
//   th_ok       : legality of the almost-full / almost-empty thresholds
package fifo_pkg;
  typedef enum logic {STD = 1'b0, FWFT = 1'b1} fifo_mode_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit th_ok(input int depth, input int af, input int ae);
    return af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
//   clk          : write clock
//   we/waddr/din : write enable, address, data
//   raddr/dout   : combinational read address and data
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         din,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end
  assign dout = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary depth, programmable thresholds, count and FWFT mode.
//   clk, rst_n                 : clock, synchronous active-low reset
//   data_in, wr_en, rd_en      : write data, push request, pop request
//   data_out, rd_valid         : read data and its qualifier
//   wr_ack, overflow, underflow: one-cycle-late outcome of the previous request
//   full, empty, almostfull, almostempty, count : occupancy status
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = FIFO_DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [FIFO_WIDTH-1:0]            data_in,
  input  logic                             wr_en,
  input  logic                             rd_en,
  output logic [FIFO_WIDTH-1:0]            data_out,
  output logic                             rd_valid,
  output logic                             wr_ack,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             full,
  output logic                             empty,
  output logic                             almostfull,
  output logic                             almostempty,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     count
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e MODE = FWFT ? fifo_pkg::FWFT : STD;
  if (FIFO_DEPTH < 2 || !th_ok(FIFO_DEPTH, AF_TH, AE_TH)) begin : g_param_chk
    $error("fifo_sync_param: FIFO_DEPTH must be >= 2 and thresholds in range");
  end
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d, mem_rd;
  logic                  rd_valid_q, rd_valid_d, wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    rd_acc      = rd_en && !empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_acc      = wr_en && (!full || rd_acc);
    wr_ptr_d    = wr_acc ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;
    rd_valid_d  = rd_acc;
    dout_d      = rd_acc ? mem_rd : dout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      dout_q      <= dout_d;
    end
  end
  // Read port is asynchronous, so a same-address write on a full FIFO still returns the old head.
  fifo_mem #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_acc && rst_n),
    .waddr(wr_ptr_q),
    .din  (data_in),
    .raddr(rd_ptr_q),
    .dout (mem_rd)
  );
  assign full        = count_q == CW'(FIFO_DEPTH);
  assign empty       = count_q == '0;
  assign almostfull  = count_q >= CW'(AF_TH);
  assign almostempty = count_q <= CW'(AE_TH);
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign data_out    = MODE == STD ? dout_q : mem_rd;
  assign rd_valid    = MODE == STD ? rd_valid_q : !empty;
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds arbitrary (non power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count output, a selectable first-word-fall-through read mode, and write-when-full pass-through on simultaneous read/write. It sits between any producer/consumer pair in the same clock domain and keeps the existing flag set, so current benches and monitors bind to it with only added signals.

## Interface
- FIFO_WIDTH, 16, data word width (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, any integer)
- AF_TH, FIFO_DEPTH-1, almostfull asserted when count ≥ AF_TH (1..FIFO_DEPTH)
- AE_TH, 1, almostempty asserted when count ≤ AE_TH (0..FIFO_DEPTH-1)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read (pop) request
- data_out  output  FIFO_WIDTH  read data
- rd_valid  output  1  data_out holds a freshly popped word (FWFT=0) / head is valid (FWFT=1)
- wr_ack  output  1  registered: previous-cycle write accepted
- overflow  output  1  registered: previous-cycle write rejected
- underflow  output  1  registered: previous-cycle read rejected
- full, empty, almostfull, almostempty  output  1  occupancy flags
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- State: wr_ptr, rd_ptr (width $clog2(FIFO_DEPTH)), count register, storage array.
- All acceptance decisions use pre-edge count.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc) — write to a full FIFO succeeds only when a read is accepted in the same cycle.
- Empty with rd_en && wr_en: write accepted, read rejected (underflow=1); applies in both modes.
- Pointers increment by 1 on acceptance; wrap from FIFO_DEPTH-1 to 0 (explicit compare, no power-of-two masking).
- count next = count + wr_acc − rd_acc; never exceeds FIFO_DEPTH, never below 0.
- full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count≥AF_TH); almostempty = (count≤AE_TH). Combinational from count register.
- wr_ack = wr_acc, overflow = wr_en && !wr_acc, underflow = rd_en && !rd_acc, all registered one cycle.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr], rd_valid <= 1; otherwise data_out holds, rd_valid <= 0.
- FWFT=1: data_out = mem[rd_ptr] combinationally; rd_valid = !empty; rd_en pops the head.
- Reset (rst_n=0 at edge): pointers, count, wr_ack, overflow, underflow, rd_valid -> 0; data_out -> 0 (FWFT=0); empty=1, almostempty=1, full=0, almostfull=0. Storage not cleared. Reset mid-operation discards all contents; requests in the reset cycle are ignored and flag nothing.

## Timing
- Write-to-read latency: word written at edge N is poppable at edge N+1 (FWFT=1: visible on data_out after edge N).
- FWFT=0 read latency: 1 cycle from accepted rd_en to data_out/rd_valid.
- Flags and count reflect state after the most recent edge; wr_ack/overflow/underflow describe the request of the preceding cycle.
- Full + rd_en + wr_en: same-address read returns the old word; new word stored; count unchanged, full stays 1.

## Structure
- Package fifo_pkg: fifo_mode_e typedef (STD, FWFT), parameter-range check function for AF_TH/AE_TH, count-width helper.
- Sub-module fifo_mem: FIFO_DEPTH × FIFO_WIDTH array, one write port, one asynchronous read port; control/flags in the top.
- Elaboration-time assertions reject FIFO_DEPTH<2 and out-of-range thresholds.

## Test plan
- Defaults, reset then 8 writes 0x0001..0x0008 -> wr_ack each cycle, count 1..8, almostfull at count 7, full at 8; 9th write -> overflow=1, count 8.
- Full FIFO, rd_en+wr_en with 0xAAAA for 1 cycle -> data_out=0x0001, wr_ack=1, overflow=0, count 8; draining then yields 0x0002..0x0008, 0xAAAA.
- Empty FIFO, rd_en only -> underflow=1, rd_valid=0; rd_en+wr_en 0x1234 -> wr_ack=1, underflow=1, count 1.
- FIFO_DEPTH=5: 12 write/read pairs streaming 0..11 -> data out in order across two pointer wraps, count never >5.
- FWFT=1: write 0x00FF -> next cycle data_out=0x00FF, rd_valid=1 with no rd_en; rd_en -> empty=1, rd_valid=0.
- Fill to 4, assert rst_n=0 one cycle with wr_en=1 -> count 0, empty=1, wr_ack=0, overflow=0 next cycle.
